// File: rtl/noc_out_arbiter.sv
// rtl/noc_out_arbiter.sv - round-robin, packet-granular switch allocator for one router output
module noc_out_arbiter #(
  parameter int DATASIZE = 40
) (
  input  logic                fifo_clk,
  input  logic                rst_n,
  input  logic [3:0]          req,
  input  logic [DATASIZE-1:0] N_data_in,
  input  logic [DATASIZE-1:0] S_data_in,
  input  logic [DATASIZE-1:0] W_data_in,
  input  logic [DATASIZE-1:0] L_data_in,
  output logic                fifo_ready_N,
  output logic                fifo_ready_S,
  output logic                fifo_ready_W,
  output logic                fifo_ready_L,
  input  logic                out_full,
  output logic [DATASIZE-1:0] out_data,
  output logic                out_valid,
  output logic [1:0]          lock_owner,
  output logic                locked,
  output logic                proto_err
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  state_t              state, state_nxt;
  logic [1:0]          rr_ptr, rr_nxt;
  logic [1:0]          owner_nxt;
  logic                err_nxt;
  logic [7:0]          req_rot;
  logic [1:0]          offset;
  logic [1:0]          winner;
  logic [1:0]          src;
  logic                pop;
  logic [DATASIZE-1:0] sel_data;
  logic [1:0]          ftype;
  logic [3:0]          grant;

  // Rotate requests so the rr_ptr source sits at bit 0, then pick the lowest set bit.
  assign req_rot = {req, req} >> rr_ptr;

  always_comb begin
    offset = 2'd0;
    casez (req_rot[3:0])
      4'b???1: offset = 2'd0;
      4'b??10: offset = 2'd1;
      4'b?100: offset = 2'd2;
      4'b1000: offset = 2'd3;
      default: offset = 2'd0;
    endcase
  end

  assign winner = rr_ptr + offset;
  assign src    = (state == LOCKED) ? lock_owner : winner;
  assign pop    = rst_n && !out_full && ((state == LOCKED) ? req[lock_owner] : (req != 4'b0000));

  always_comb begin
    sel_data = N_data_in;
    case (src)
      2'd0: sel_data = N_data_in;
      2'd1: sel_data = S_data_in;
      2'd2: sel_data = W_data_in;
      2'd3: sel_data = L_data_in;
      default: sel_data = N_data_in;
    endcase
  end

  assign ftype = sel_data[DATASIZE-1 -: 2];
  assign grant = pop ? (4'b0001 << src) : 4'b0000;

  assign fifo_ready_N = grant[0];
  assign fifo_ready_S = grant[1];
  assign fifo_ready_W = grant[2];
  assign fifo_ready_L = grant[3];
  assign locked       = (state == LOCKED);

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    owner_nxt = lock_owner;
    err_nxt   = proto_err;
    if (pop) begin
      if (state == IDLE) begin
        if (ftype == T_HEAD) begin
          state_nxt = LOCKED;
          owner_nxt = src;
        end else begin
          rr_nxt = src + 2'd1;
          if (ftype != T_SINGLE) err_nxt = 1'b1;
        end
      end else begin
        if (ftype == T_TAIL) begin
          state_nxt = IDLE;
          rr_nxt    = src + 2'd1;
        end else if (ftype != T_BODY) begin
          err_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge fifo_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= 2'd0;
      lock_owner <= 2'd0;
      proto_err  <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_nxt;
      lock_owner <= owner_nxt;
      proto_err  <= err_nxt;
      out_valid  <= pop;
      if (pop) out_data <= sel_data;
    end
  end

endmodule
